// File: rtl/pacman_pio_pkg.sv
// pacman_pio_pkg
// Shared register map for the frame-synchronised PIO block: register
// offsets within a 4-word block, CTRL bit positions and STATUS fields.
package pacman_pio_pkg;

  // Offsets inside a per-channel block
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_OUTSET = 2'd1;
  localparam logic [1:0] REG_OUTCLR = 2'd2;
  localparam logic [1:0] REG_ACTIVE = 2'd3;

  // Offsets inside the global block (block index == CHANNELS)
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // CTRL bits
  localparam int CTRL_AUTO   = 0;
  localparam int CTRL_COMMIT = 1;

  // STATUS fields
  localparam int STAT_PENDING   = 0;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_MSB = 15;

endpackage

// File: rtl/pacman_pio_channel.sv
// pacman_pio_channel
// One output channel: a software-facing shadow register and the
// hardware-facing active register that copies the shadow on commit.
// Set/clear update exists only when PIO_SETCLR_EN is defined.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   we_data           load shadow with wdata
//   we_set, we_clr    shadow |= wdata / shadow &= ~wdata (PIO_SETCLR_EN only)
//   wdata             write data, already truncated to WIDTH
//   commit            copy shadow into active at this edge
//   shadow, active    current register contents
module pacman_pio_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_data,
`ifdef PIO_SETCLR_EN
  input  logic             we_set,
  input  logic             we_clr,
`endif
  input  logic [WIDTH-1:0] wdata,
  input  logic             commit,
  output logic [WIDTH-1:0] shadow,
  output logic [WIDTH-1:0] active
);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: shadow is reset too, so a reset mid-frame discards any
      // half-written settings instead of committing stale values later.
      shadow <= '0;
      active <= '0;
    end else begin
      // NOTE: non-blocking assignment makes active take the pre-write shadow
      // when a commit and a shadow write land on the same edge.
      if (commit) active <= shadow;
      if (we_data) shadow <= wdata;
`ifdef PIO_SETCLR_EN
      else if (we_set) shadow <= shadow | wdata;
      else if (we_clr) shadow <= shadow & ~wdata;
`endif
    end
  end

endmodule

// File: rtl/pacman_soc_pio_frame_out.sv
// pacman_soc_pio_frame_out
// Avalon-MM slave driving CHANNELS output ports of WIDTH bits. Software
// writes shadow registers; all channels move to the active registers
// together on a COMMIT write or, with AUTO set, on a frame sync pulse
// while updates are pending.
// Optional feature macro: PIO_SETCLR_EN enables the OUTSET/OUTCLR registers.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   address           word address {ch, reg[1:0]}
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata         write data (bits above WIDTH ignored)
//   readdata          combinational read data, zero-extended
//   sync_pulse        one-cycle frame-start strobe
//   out_port          active values, channel n at [n*WIDTH +: WIDTH]
//   commit_strobe     one-cycle pulse in the cycle out_port changes
module pacman_soc_pio_frame_out
  import pacman_pio_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int ADDR_W   = $clog2(CHANNELS + 1) + 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic                      sync_pulse,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic                      commit_strobe
);

  localparam int CH_W = ADDR_W - 2;

  logic [CH_W-1:0]  ch_sel;
  logic [1:0]       reg_sel;
  logic             wr;
  logic             glob_sel;
  logic             ctrl_wr;
  logic             commit;
  logic             shadow_wr;
  logic             auto_q;
  logic             pending_q;
  logic [7:0]       count_q;
  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [WIDTH-1:0] active [CHANNELS];
  logic [CHANNELS-1:0] we_data;
`ifdef PIO_SETCLR_EN
  logic [CHANNELS-1:0] we_set;
  logic [CHANNELS-1:0] we_clr;
`endif

  // Upper writedata bits are deliberately ignored.
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign ch_sel   = address[ADDR_W-1:2];
  assign reg_sel  = address[1:0];
  assign wr       = chipselect && !write_n;
  assign glob_sel = (ch_sel == CH_W'(CHANNELS));
  assign ctrl_wr  = wr && glob_sel && (reg_sel == REG_CTRL);

  // A COMMIT write and a qualifying sync in the same cycle are one commit.
  assign commit = (ctrl_wr && writedata[CTRL_COMMIT]) ||
                  (sync_pulse && auto_q && pending_q);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic hit;
    assign hit        = wr && (ch_sel == CH_W'(i));
    assign we_data[i] = hit && (reg_sel == REG_DATA);
`ifdef PIO_SETCLR_EN
    assign we_set[i]  = hit && (reg_sel == REG_OUTSET);
    assign we_clr[i]  = hit && (reg_sel == REG_OUTCLR);
`endif

    pacman_pio_channel #(.WIDTH(WIDTH)) u_channel (
      .clk     (clk),
      .reset   (reset),
      .we_data (we_data[i]),
`ifdef PIO_SETCLR_EN
      .we_set  (we_set[i]),
      .we_clr  (we_clr[i]),
`endif
      .wdata   (writedata[WIDTH-1:0]),
      .commit  (commit),
      .shadow  (shadow[i]),
      .active  (active[i])
    );

    assign out_port[i*WIDTH +: WIDTH] = active[i];
  end

`ifdef PIO_SETCLR_EN
  assign shadow_wr = |{we_data, we_set, we_clr};
`else
  assign shadow_wr = |we_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      auto_q        <= 1'b0;
      pending_q     <= 1'b0;
      count_q       <= '0;
      commit_strobe <= 1'b0;
    end else begin
      if (ctrl_wr) auto_q <= writedata[CTRL_AUTO];
      // A shadow write in the commit cycle leaves new data pending.
      if (shadow_wr)   pending_q <= 1'b1;
      else if (commit) pending_q <= 1'b0;
      if (commit) count_q <= count_q + 8'd1;
      commit_strobe <= commit;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns readdata and no latch forms.
    readdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == CH_W'(i)) begin
        if (reg_sel == REG_DATA)        readdata = 32'(shadow[i]);
        else if (reg_sel == REG_ACTIVE) readdata = 32'(active[i]);
      end
    end
    if (glob_sel) begin
      if (reg_sel == REG_CTRL) begin
        readdata[CTRL_AUTO] = auto_q;
      end else if (reg_sel == REG_STATUS) begin
        readdata[STAT_PENDING]                  = pending_q;
        readdata[STAT_COUNT_MSB:STAT_COUNT_LSB] = count_q;
      end
    end
  end

endmodule

// File: tb/tb_pacman_soc_pio_frame_out.sv
// tb_pacman_soc_pio_frame_out
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural register-map model. Works with or without PIO_SETCLR_EN.
module tb_pacman_soc_pio_frame_out;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int ADDR_W   = $clog2(CHANNELS + 1) + 2;
`ifdef PIO_SETCLR_EN
  localparam bit SETCLR = 1'b1;
`else
  localparam bit SETCLR = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic [ADDR_W-1:0]         address;
  logic                      chipselect;
  logic                      write_n;
  logic [31:0]               writedata;
  logic [31:0]               readdata;
  logic                      sync_pulse;
  logic [CHANNELS*WIDTH-1:0] out_port;
  logic                      commit_strobe;

  always #5 clk = ~clk;

  pacman_soc_pio_frame_out #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .sync_pulse    (sync_pulse),
    .out_port      (out_port),
    .commit_strobe (commit_strobe)
  );

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_shadow [CHANNELS];
  logic [WIDTH-1:0] m_active [CHANNELS];
  bit               m_auto, m_pending, m_strobe;
  int               m_count;

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [ADDR_W-1:0] mk(input int ch, input int r);
    return ADDR_W'(ch * 4 + r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_auto = 0; m_pending = 0; m_strobe = 0; m_count = 0;
  endtask

  // Effect of one clock edge given the inputs present during that cycle.
  task automatic model_clock(input bit wr, input logic [ADDR_W-1:0] a,
                             input logic [31:0] wd, input bit sync);
    int ch, r;
    bit wrote_shadow, do_commit;
    ch = int'(a) / 4;
    r  = int'(a) % 4;
    wrote_shadow = 0;
    do_commit = (wr && ch == CHANNELS && r == 0 && wd[1]) ||
                (sync && m_auto && m_pending);
    if (do_commit) begin
      for (int i = 0; i < CHANNELS; i++) m_active[i] = m_shadow[i];
      m_count = (m_count + 1) % 256;
    end
    m_strobe = do_commit;
    if (wr && ch < CHANNELS) begin
      if (r == 0) begin
        m_shadow[ch] = wd[WIDTH-1:0]; wrote_shadow = 1;
      end else if (SETCLR && r == 1) begin
        m_shadow[ch] = m_shadow[ch] | wd[WIDTH-1:0]; wrote_shadow = 1;
      end else if (SETCLR && r == 2) begin
        m_shadow[ch] = m_shadow[ch] & ~wd[WIDTH-1:0]; wrote_shadow = 1;
      end
    end
    if (wr && ch == CHANNELS && r == 0) m_auto = wd[0];
    if (wrote_shadow)   m_pending = 1;
    else if (do_commit) m_pending = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
    int ch, r;
    logic [31:0] v;
    ch = int'(a) / 4;
    r  = int'(a) % 4;
    v  = 32'h0;
    if (ch < CHANNELS) begin
      if (r == 0)      v = 32'(m_shadow[ch]);
      else if (r == 3) v = 32'(m_active[ch]);
    end else if (ch == CHANNELS) begin
      if (r == 0)      v = {31'h0, m_auto};
      else if (r == 1) v = {16'h0, 8'(m_count), 7'h0, m_pending};
    end
    return v;
  endfunction

  function automatic logic [CHANNELS*WIDTH-1:0] model_out();
    logic [CHANNELS*WIDTH-1:0] v;
    for (int i = 0; i < CHANNELS; i++) v[i*WIDTH +: WIDTH] = m_active[i];
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    chipselect = 0; write_n = 1; writedata = '0; sync_pulse = 0; address = '0;
  endtask

  task automatic step(input bit wr, input logic [ADDR_W-1:0] a,
                      input logic [31:0] wd, input bit sync);
    address = a; chipselect = wr; write_n = !wr; writedata = wd; sync_pulse = sync;
    model_clock(wr, a, wd, sync);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_out"}, 64'(out_port), 64'(model_out()));
    check({tag, "_strobe"}, 64'(commit_strobe), 64'(m_strobe));
  endtask

  task automatic rd_check(input string tag, input logic [ADDR_W-1:0] a);
    address = a; chipselect = 1; write_n = 1;
    #1;
    check(tag, 64'(readdata), 64'(model_read(a)));
    chipselect = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1;
    idle_inputs();
    model_reset();
    do_reset();

    // Reset state: everything reads zero.
    check("rst_out", 64'(out_port), 64'h0);
    check("rst_strobe", 64'(commit_strobe), 64'h0);
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      address = ADDR_W'(a); chipselect = 1; write_n = 1;
      #1;
      check($sformatf("rst_rd_%0d", a), 64'(readdata), 64'h0);
    end
    chipselect = 0;

    // Manual commit path, AUTO off.
    step(1, mk(1, 0), 32'hA5, 0);
    step(0, '0, '0, 1);
    check("noauto_ch1", 64'(out_port[15:8]), 64'h0);
    rd_check("noauto_status", mk(CHANNELS, 1));
    check("noauto_pending", 64'(readdata[0]), 64'h1);
    step(1, mk(CHANNELS, 0), 32'h2, 0);
    check("commit_ch1", 64'(out_port[15:8]), 64'hA5);
    check("commit_strobe", 64'(commit_strobe), 64'h1);
    rd_check("commit_active", mk(1, 3));
    step(0, '0, '0, 0);
    check("strobe_drop", 64'(commit_strobe), 64'h0);
    rd_check("commit_status", mk(CHANNELS, 1));
    check("commit_status_val", 64'(readdata), 64'h100);

    // AUTO commit with set/clear.
    step(1, mk(CHANNELS, 0), 32'h1, 0);
    step(1, mk(0, 0), 32'h0F, 0);
    step(1, mk(0, 1), 32'h30, 0);
    step(1, mk(0, 2), 32'h01, 0);
    step(0, '0, '0, 1);
    check("setclr_ch0", 64'(out_port[7:0]), SETCLR ? 64'h3E : 64'h0F);
    check_outs("setclr");
    rd_check("outset_rd", mk(0, 1));
    rd_check("outclr_rd", mk(0, 2));

    // Shadow write coinciding with a qualifying sync.
    step(1, mk(2, 0), 32'h22, 0);
    step(1, mk(2, 0), 32'h11, 1);
    check("coinc_ch2", 64'(out_port[23:16]), 64'h22);
    check_outs("coinc");
    rd_check("coinc_shadow", mk(2, 0));
    rd_check("coinc_status", mk(CHANNELS, 1));
    check("coinc_pending", 64'(readdata[0]), 64'h1);
    step(0, '0, '0, 1);
    check("coinc_next_ch2", 64'(out_port[23:16]), 64'h11);

    // Writes to reserved and out-of-range addresses change nothing.
    for (int ch = CHANNELS; ch < (1 << (ADDR_W - 2)); ch++)
      for (int r = 0; r < 4; r++)
        if (ch != CHANNELS || r >= 2) begin
          step(1, mk(ch, r), $urandom, 0);
          check_outs($sformatf("ign_%0d_%0d", ch, r));
          rd_check($sformatf("ign_rd_%0d_%0d", ch, r), mk(ch, r));
        end
    rd_check("ign_status", mk(CHANNELS, 1));
    rd_check("ign_ctrl", mk(CHANNELS, 0));

    // Back-to-back commits, and COMMIT together with a qualifying sync.
    step(1, mk(3, 0), 32'h77, 0);
    step(1, mk(CHANNELS, 0), 32'h3, 1);
    check_outs("both");
    rd_check("both_status", mk(CHANNELS, 1));
    step(1, mk(CHANNELS, 0), 32'h3, 0);
    check_outs("b2b");
    rd_check("b2b_status", mk(CHANNELS, 1));

    // Reset while an update is pending discards it.
    step(1, mk(0, 0), 32'h55, 0);
    do_reset();
    step(0, '0, '0, 1);
    check("rstmid_out", 64'(out_port), 64'h0);
    check("rstmid_strobe", 64'(commit_strobe), 64'h0);
    rd_check("rstmid_status", mk(CHANNELS, 1));
    rd_check("rstmid_shadow", mk(0, 0));

    // Commit counter wrap.
    for (int i = 0; i < 255; i++) step(1, mk(CHANNELS, 0), 32'h2, 0);
    rd_check("cnt255", mk(CHANNELS, 1));
    check("cnt255_val", 64'(readdata), 64'hFF00);
    step(1, mk(CHANNELS, 0), 32'h2, 0);
    rd_check("cnt_wrap", mk(CHANNELS, 1));
    check("cnt_wrap_val", 64'(readdata), 64'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bit wr, sync;
      logic [ADDR_W-1:0] a;
      if ($urandom_range(0, 149) == 0) do_reset();
      wr   = $urandom_range(0, 2) != 0;
      sync = $urandom_range(0, 3) == 0;
      a    = ADDR_W'($urandom);
      step(wr, a, $urandom, sync);
      check_outs($sformatf("rnd%0d", n));
      rd_check($sformatf("rnd_rd%0d", n), ADDR_W'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
